// File: rtl/note_pkg.sv
// note_pkg: shared types and constants for the note scheduler.
//   state_t    - scheduler FSM states (IDLE/PLAY/LIVE/GAP)
//   note_t     - 3-bit note code, 0 = rest/silence
//   ASCII_*    - serial command bytes ('0', '1', '7', ESC)
//   NOTE_REST  - code used for a rest and for silence
//   is_note_byte / byte_to_note - serial byte decode helpers
package note_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    LIVE = 2'd2,
    GAP  = 2'd3
  } state_t;

  typedef logic [2:0] note_t;

  localparam logic [7:0] ASCII_REST    = 8'h30;  // '0'
  localparam logic [7:0] ASCII_NOTE_LO = 8'h31;  // '1'
  localparam logic [7:0] ASCII_NOTE_HI = 8'h37;  // '7'
  localparam logic [7:0] ASCII_FLUSH   = 8'h1B;  // ESC

  localparam note_t NOTE_REST = 3'd0;

  // '0'..'7' are queueable entries; everything else except ESC is ignored.
  function automatic logic is_note_byte(input logic [7:0] b);
    return (b == ASCII_REST) || ((b >= ASCII_NOTE_LO) && (b <= ASCII_NOTE_HI));
  endfunction

  // 0x30..0x37 carry the note code directly in their low three bits.
  function automatic note_t byte_to_note(input logic [7:0] b);
    return b[2:0];
  endfunction

endpackage

// File: rtl/note_fifo.sv
// note_fifo: synchronous FIFO of note codes with flush.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, din    - write request and data
//   pop, dout    - read request; dout shows the head entry (valid when !empty)
//   flush        - empties the FIFO; wins over push and pop in the same cycle
//   count        - registered number of entries
//   full         - registered, high when count == DEPTH
//   empty        - count == 0
//   overflow     - sticky, set when a push is dropped because the FIFO is full
// Handshake: push is accepted when not full, or when full and a pop is
// accepted in the same cycle; pop is accepted only when not empty.
module note_fifo
  import note_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  note_t      din,
  output note_t      dout,
  output logic [4:0] count,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  note_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;
  logic [4:0]      count_next;

  assign empty   = (count == 5'd0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = 5'd0;
    end else if (do_push && !do_pop) begin
      count_next = count + 5'd1;
    end else if (!do_push && do_pop) begin
      count_next = count - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count <= count_next;
      full  <= (count_next == 5'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      // Dropped push: full with no simultaneous pop and no flush.
      if (push && !flush && full && !do_pop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: queues notes received as ASCII bytes and plays them for a
// fixed duration each, letting a live button note preempt playback.
// Optional feature macro: NOTE_SCHED_GAP_EN adds a silent GAP state of
// GAP_TICKS cycles between queued notes.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   rx_valid, rx_data     - one-cycle strobe with a received serial byte
//   btn_valid, btn_note   - live note request (level) and its code
//   note_out              - code to the tone generator, 0 = silence
//   note_active           - note sounding or a rest being timed
//   note_done             - one-cycle pulse when a queued entry completes
//   fifo_count, fifo_full - queue occupancy (registered)
//   overflow              - sticky, a note byte was dropped while full
//   fsm_state             - current scheduler state, for observation
module note_scheduler
  import note_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int NOTE_TICKS = 12500000,
  parameter int GAP_TICKS  = 1250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       btn_valid,
  input  logic [2:0] btn_note,
  output logic [2:0] note_out,
  output logic       note_active,
  output logic       note_done,
  output logic [4:0] fifo_count,
  output logic       fifo_full,
  output logic       overflow,
  output state_t     fsm_state
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("note_scheduler: DEPTH must be a power of two in 2..16");
  end
  if (NOTE_TICKS < 1 || GAP_TICKS < 2) begin : g_bad_ticks
    $error("note_scheduler: NOTE_TICKS must be >= 1 and GAP_TICKS >= 2");
  end

  localparam logic [23:0] NOTE_LOAD = 24'(NOTE_TICKS - 1);
`ifdef NOTE_SCHED_GAP_EN
  // The IDLE turnaround cycle after GAP is also silent, so GAP itself
  // lasts one cycle less than the total silence.
  localparam logic [23:0] GAP_LOAD = 24'(GAP_TICKS - 2);
`endif

  // ---------------- byte decode (one cycle of latency) ----------------
  logic  push_q;
  logic  flush_q;
  note_t push_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q      <= 1'b0;
      flush_q     <= 1'b0;
      push_code_q <= NOTE_REST;
    end else begin
      push_q  <= rx_valid && is_note_byte(rx_data);
      flush_q <= rx_valid && (rx_data == ASCII_FLUSH);
      if (rx_valid) push_code_q <= byte_to_note(rx_data);
    end
  end

  // ---------------- queue ----------------
  note_t fifo_head;
  logic  fifo_empty;
  logic  pop;

  note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_q),
    .pop      (pop),
    .flush    (flush_q),
    .din      (push_code_q),
    .dout     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  // ---------------- scheduler FSM ----------------
  state_t      state, state_n;
  logic [23:0] timer, timer_n;
  note_t       cur_code, code_n;   // queued note being played or frozen
  logic        preempt, preempt_n; // a PLAY is frozen behind LIVE
  note_t       note_n;
  logic        active_n;
  logic        done_n;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= 24'd0;
      cur_code    <= NOTE_REST;
      preempt     <= 1'b0;
      note_out    <= NOTE_REST;
      note_active <= 1'b0;
      note_done   <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      cur_code    <= code_n;
      preempt     <= preempt_n;
      note_out    <= note_n;
      note_active <= active_n;
      note_done   <= done_n;
    end
  end

  // note_out is held by default: after a note ends it stays on for the
  // single IDLE cycle, so back-to-back notes have no audible gap.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    code_n    = cur_code;
    preempt_n = preempt;
    note_n    = note_out;
    done_n    = 1'b0;
    pop       = 1'b0;

    if (flush_q) begin
      state_n   = IDLE;
      timer_n   = 24'd0;
      preempt_n = 1'b0;
      note_n    = NOTE_REST;
    end else begin
      case (state)
        IDLE: begin
          if (btn_valid) begin
            state_n = LIVE;
            note_n  = btn_note;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            code_n  = fifo_head;
            timer_n = NOTE_LOAD;
            state_n = PLAY;
            note_n  = fifo_head;
          end else begin
            note_n = NOTE_REST;
          end
        end

        PLAY: begin
          if (timer == 24'd0) begin
            done_n = 1'b1;
            if (btn_valid) begin
              state_n = LIVE;
              note_n  = btn_note;
            end else begin
`ifdef NOTE_SCHED_GAP_EN
              state_n = GAP;
              timer_n = GAP_LOAD;
              note_n  = NOTE_REST;
`else
              state_n = IDLE;
`endif
            end
          end else begin
            // The preempting cycle still counts as a played tick.
            timer_n = timer - 24'd1;
            if (btn_valid) begin
              state_n   = LIVE;
              preempt_n = 1'b1;
              note_n    = btn_note;
            end
          end
        end

        LIVE: begin
          if (btn_valid) begin
            note_n = btn_note;
          end else if (preempt) begin
            state_n   = PLAY;
            preempt_n = 1'b0;
            note_n    = cur_code;
          end else begin
            state_n = IDLE;
            note_n  = NOTE_REST;
          end
        end

`ifdef NOTE_SCHED_GAP_EN
        GAP: begin
          note_n = NOTE_REST;
          if (btn_valid) begin
            state_n = LIVE;
            note_n  = btn_note;
          end else if (timer == 24'd0) begin
            state_n = IDLE;
          end else begin
            timer_n = timer - 24'd1;
          end
        end
`endif

        default: begin
          state_n = IDLE;
          note_n  = NOTE_REST;
        end
      endcase
    end

    active_n = (state_n == PLAY) || (note_n != NOTE_REST);
  end

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed self-checking bench for note_scheduler with
// NOTE_TICKS=10, GAP_TICKS=3, DEPTH=4. Honours NOTE_SCHED_GAP_EN when defined.
module tb_note_scheduler;
  import note_pkg::*;

  localparam int DEPTH      = 4;
  localparam int NOTE_TICKS = 10;
  localparam int GAP_TICKS  = 3;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       rx_valid  = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       btn_valid = 1'b0;
  logic [2:0] btn_note  = 3'd0;
  logic [2:0] note_out;
  logic       note_active;
  logic       note_done;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       overflow;
  state_t     fsm_state;

  int n_cmp      = 0;
  int n_bad      = 0;
  int done_total = 0;

  logic [2:0] exp_q[$];

  note_scheduler #(
    .DEPTH      (DEPTH),
    .NOTE_TICKS (NOTE_TICKS),
    .GAP_TICKS  (GAP_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .btn_valid   (btn_valid),
    .btn_note    (btn_note),
    .note_out    (note_out),
    .note_active (note_active),
    .note_done   (note_done),
    .fifo_count  (fifo_count),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (note_done) done_total++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    btn_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Waits for PLAY, then counts PLAY cycles showing code. Returns in the
  // first cycle after PLAY, where note_done must be high.
  task automatic play_note(input string tag, input logic [2:0] code, input int ticks,
                           output int waited);
    int n;
    int early;
    waited = 0;
    while (fsm_state != PLAY && waited < 60) begin
      step();
      waited++;
    end
    check_eq({tag, "_start"}, 32'(fsm_state == PLAY), 1);
    check_eq({tag, "_code"}, 32'(note_out), 32'(code));
    n     = 0;
    early = 0;
    while (fsm_state == PLAY && n < 200) begin
      if (note_out == code) n++;
      if (note_done) early++;
      step();
    end
    check_eq({tag, "_ticks"}, n, ticks);
    check_eq({tag, "_done"}, 32'(note_done), 1);
    check_eq({tag, "_early_done"}, early, 0);
  endtask

  // Scoreboard: next expected queued note comes from exp_q.
  task automatic play_next(input string tag, output int waited);
    logic [2:0] code;
    code = exp_q.pop_front();
    play_note(tag, code, NOTE_TICKS, waited);
  endtask

  // ---------------- stimulus ----------------
  int w;
  int n;
  int live;
  int base;
  int silent;
  int exp_wait;
  int exp_silent;

  initial begin
`ifdef NOTE_SCHED_GAP_EN
    exp_wait   = 3;
    exp_silent = 3;
`else
    exp_wait   = 1;
    exp_silent = 0;
`endif

    // Reset state.
    rst_n = 1'b0;
    step();
    step();
    check_eq("rst_note_out", 32'(note_out), 0);
    check_eq("rst_active", 32'(note_active), 0);
    check_eq("rst_done", 32'(note_done), 0);
    check_eq("rst_count", 32'(fifo_count), 0);
    check_eq("rst_full", 32'(fifo_full), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
    rst_n = 1'b1;
    step();

    // Scenario 1: '3','5' back to back.
    send_byte(8'h33);
    exp_q.push_back(3'd3);
    send_byte(8'h35);
    exp_q.push_back(3'd5);
    play_next("s1_n1", w);
`ifndef NOTE_SCHED_GAP_EN
    check_eq("s1_hold", 32'(note_out), 3);
`endif
    play_next("s1_n2", w);
    check_eq("s1_next_wait", w, exp_wait);
    step();
    check_eq("s1_silent", 32'(note_out), 0);
    check_eq("s1_inactive", 32'(note_active), 0);
    check_eq("s1_count", 32'(fifo_count), 0);

    // Scenario 2: five pushes while held in LIVE.
    reset_dut();
    btn_note  = 3'd7;
    btn_valid = 1'b1;
    step();
    step();
    for (int i = 1; i <= 5; i++) send_byte(8'h30 + 8'(i));
    step();
    step();
    check_eq("s2_count", 32'(fifo_count), 4);
    check_eq("s2_full", 32'(fifo_full), 1);
    check_eq("s2_overflow", 32'(overflow), 1);
    check_eq("s2_state", 32'(fsm_state), 32'(LIVE));
    check_eq("s2_live_note", 32'(note_out), 7);
    for (int i = 1; i <= 4; i++) exp_q.push_back(3'(i));
    btn_valid = 1'b0;
    play_next("s2_n1", w);
    for (int i = 2; i <= 4; i++) begin
      play_next($sformatf("s2_n%0d", i), w);
      check_eq($sformatf("s2_wait%0d", i), w, exp_wait);
    end
    step();
    check_eq("s2_count_end", 32'(fifo_count), 0);
    check_eq("s2_full_end", 32'(fifo_full), 0);
    check_eq("s2_overflow_sticky", 32'(overflow), 1);

    // Scenario 3: live note 6 preempts note 2 on its 4th tick for 7 cycles.
    reset_dut();
    send_byte(8'h32);
    w = 0;
    while (fsm_state != PLAY && w < 40) begin
      step();
      w++;
    end
    check_eq("s3_start", 32'(fsm_state == PLAY), 1);
    base = done_total;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (note_out == 3'd2) n++;
      step();
    end
    btn_note  = 3'd6;
    btn_valid = 1'b1;
    if (note_out == 3'd2) n++;
    check_eq("s3_head_ticks", n, 4);
    live = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (note_out == 3'd6) live++;
    end
    btn_valid = 1'b0;
    check_eq("s3_live_cycles", live, 7);
    play_note("s3_resume", 3'd2, 6, w);
    check_eq("s3_resume_wait", w, 1);
    step();
    check_eq("s3_single_done", done_total - base, 1);

    // Scenario 4: flush during PLAY with two entries queued.
    reset_dut();
    base = done_total;
    send_byte(8'h31);
    send_byte(8'h32);
    send_byte(8'h33);
    w = 0;
    while (fsm_state != PLAY && w < 40) begin
      step();
      w++;
    end
    check_eq("s4_code", 32'(note_out), 1);
    step();
    step();
    check_eq("s4_queued", 32'(fifo_count), 2);
    send_byte(8'h1B);
    step();
    check_eq("s4_note", 32'(note_out), 0);
    check_eq("s4_count", 32'(fifo_count), 0);
    check_eq("s4_state", 32'(fsm_state), 32'(IDLE));
    check_eq("s4_active", 32'(note_active), 0);
    repeat (12) step();
    check_eq("s4_no_done", done_total - base, 0);
    check_eq("s4_quiet", 32'(note_out), 0);

    // Scenario 5: non-note bytes are ignored.
    reset_dut();
    send_byte(8'h41);
    send_byte(8'h39);
    send_byte(8'h00);
    repeat (3) step();
    check_eq("s5_count", 32'(fifo_count), 0);
    check_eq("s5_overflow", 32'(overflow), 0);
    check_eq("s5_state", 32'(fsm_state), 32'(IDLE));
    check_eq("s5_note", 32'(note_out), 0);

    // Scenario 6: silence between two queued notes.
    reset_dut();
    send_byte(8'h31);
    send_byte(8'h32);
    play_note("s6_n1", 3'd1, NOTE_TICKS, w);
    silent = 0;
    w = 0;
    while (fsm_state != PLAY && w < 40) begin
      if (note_out == 3'd0) silent++;
      step();
      w++;
    end
    check_eq("s6_silent", silent, exp_silent);
    check_eq("s6_n2_code", 32'(note_out), 2);

    // Rest entry: '0' is timed like a note with note_out = 0.
    reset_dut();
    send_byte(8'h30);
    w = 0;
    while (fsm_state != PLAY && w < 40) begin
      step();
      w++;
    end
    check_eq("rest_active", 32'(note_active), 1);
    play_note("rest", 3'd0, NOTE_TICKS, w);

    // Reset mid-note silences the output without waiting for a clock.
    reset_dut();
    send_byte(8'h34);
    w = 0;
    while (fsm_state != PLAY && w < 40) begin
      step();
      w++;
    end
    check_eq("mid_playing", 32'(note_out), 4);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_note", 32'(note_out), 0);
    check_eq("mid_rst_active", 32'(note_active), 0);
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
NOTE_SCHEDULER -- requirements
Module: note_scheduler

Interface
REQ-001 Parameter DEPTH, default 8: note FIFO depth; power of two, 2..16.
REQ-002 Parameter NOTE_TICKS, default 12500000: clk cycles per queued note (250 ms at 50 MHz); width 24 bits.
REQ-003 Parameter GAP_TICKS, default 1250000: clk cycles of silence between queued notes; used only with the gap feature.
REQ-004 clk  in  1  single system clock; all logic is clocked on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data holds a received serial byte.
REQ-007 rx_data  in  8  received ASCII byte.
REQ-008 btn_valid  in  1  level; a live (button) note is requested, already debounced.
REQ-009 btn_note  in  3  live note code, 1..7.
REQ-010 note_out  out  3  note code to the tone generator; 0 = silence.
REQ-011 note_active  out  1  high while note_out is nonzero or a rest is being timed.
REQ-012 note_done  out  1  one-cycle pulse when a queued note or rest completes its full duration.
REQ-013 fifo_count  out  5  current number of queued entries.
REQ-014 fifo_full  out  1  high when fifo_count == DEPTH.
REQ-015 overflow  out  1  sticky; set when a valid note byte arrives while full.

Function
REQ-016 Byte decode: ASCII '1'..'7' (0x31..0x37) -> note 1..7; '0' (0x30) -> rest (code 0); 0x1B -> flush command; all other bytes are ignored.
REQ-017 A decoded note or rest is pushed in the cycle after its rx_valid strobe; rx_valid with a non-note byte has no effect.
REQ-018 Push while full is dropped, FIFO contents are unchanged, and overflow is set.
REQ-019 A push and a pop in the same cycle while full are both accepted, with no overflow.
REQ-020 Flush empties the FIFO, aborts a PLAY or GAP in progress, returns the FSM to IDLE, and does not pulse note_done; flush takes priority over a push or pop in the same cycle.
REQ-021 FSM states: IDLE, PLAY, LIVE, GAP.
REQ-022 IDLE: when btn_valid is high, go to LIVE; otherwise, when the FIFO is non-empty, pop the head, load the tick timer with NOTE_TICKS-1, and go to PLAY.
REQ-023 PLAY: note_out = the popped code; the timer decrements each cycle; at timer 0, pulse note_done and go to GAP if the gap feature is enabled, otherwise go to IDLE.
REQ-024 LIVE: note_out = btn_note, with 0 clamped to silence, combinationally registered with one cycle of latency; the FIFO is not popped; on btn_valid low, go to IDLE, or go to PLAY if a preempted note is pending.
REQ-025 btn_valid high during PLAY or GAP preempts it in the next cycle; the PLAY timer value and code are frozen and then resumed with the remaining ticks after LIVE ends; a preempted GAP is discarded.
REQ-026 Back-to-back queued notes with the gap feature disabled: the next note_out is valid the cycle after note_done, and note_out holds its value across IDLE for that single cycle.
REQ-027 fifo_count, fifo_full, and overflow are registered and update in the cycle after the causing event.

Reset
REQ-028 On rst_n low: FSM = IDLE, FIFO is empty, timer = 0, preempt flag is clear, note_out = 0, note_active = 0, note_done = 0, fifo_count = 0, fifo_full = 0, overflow = 0.
REQ-029 The only way to clear overflow is reset.
REQ-030 Reset asserted mid-note silences note_out immediately (asynchronously).

Configuration
REQ-031 NOTE_SCHED_GAP_EN defined: the GAP state is compiled in; after each completed queued note, note_out = 0 and note_active = 0 for GAP_TICKS cycles, then the FSM returns to IDLE.
REQ-032 NOTE_SCHED_GAP_EN undefined: the GAP state, its timer compare, and the GAP_TICKS logic are absent, and PLAY goes directly to IDLE.

Structure
REQ-033 Shared package note_pkg holds the following: the state enum (IDLE/PLAY/LIVE/GAP), the 3-bit note code type, the ASCII constants (0x30, 0x31, 0x37, 0x1B), and the NOTE_REST = 0 constant.
REQ-034 One sub-module, note_fifo (synchronous FIFO with push, pop, flush, count, and full), is instantiated once; the decode logic and the FSM stay in note_scheduler.

Verification
REQ-035 Bench runs with NOTE_TICKS=10, GAP_TICKS=3, and DEPTH=4.
REQ-036 Scenario 1: reset, then bytes '3','5' -> note_out = 3 for 10 cycles, note_done pulse, then note_out = 5 for 10 cycles, then note_out = 0 and fifo_count returns to 0.
REQ-037 Scenario 2: push 5 notes with the FSM held in LIVE -> fifo_count = 4, fifo_full = 1, overflow = 1, and 4 notes play in order after release.
REQ-038 Scenario 3: btn_valid with btn_note = 6 asserted on tick 4 of note 2 for 7 cycles -> note_out = 6 for those cycles, then note 2 resumes for the remaining 6 ticks, with a single note_done.
REQ-039 Scenario 4: flush (0x1B) during PLAY with 2 queued -> note_out = 0, fifo_count = 0, no note_done, and the FSM is in IDLE.
REQ-040 Scenario 5: bytes 'A', '9', 0x00 -> no push, fifo_count stays 0, overflow stays 0.
REQ-041 Scenario 6: with NOTE_SCHED_GAP_EN, '1','2' -> 3 silent cycles between note 1 and note 2; without the macro -> 0 silent cycles.
